tx_icmp_reply: RTL and testbench

- Downstream stage of the ICMP receive parser.
- Captures the parser's AXIS stream (IP identification, TTL, echo body) and its 32-bit unfolded payload sum.
- On the parser's trigger, builds a complete 74-byte Ethernet/IPv4/ICMP echo-reply frame and streams it byte-wise to the TX MAC arbiter.
- Computes both the IPv4 header checksum and the ICMP checksum internally.

---
 rtl/tx_icmp_reply.sv | 243 ++++++++++++++++++++++++
 tb/tb_tx_icmp_reply.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_icmp_reply.sv
// ICMP echo-reply transmitter.
//
// Captures the identification, TTL and echo body that the ICMP receive parser
// streams in. Waits for the parser's trigger, then computes the IPv4 header
// checksum and the ICMP checksum. It then streams a fixed-length
// Ethernet/IPv4/ICMP echo-reply frame, one byte per handshake, to the TX MAC
// arbiter.
//
// Handshake rule (both AXIS ports): a byte moves on a clock edge where
// TVALID && TREADY. A source holds TDATA/TLAST stable while TVALID && !TREADY.
//
// Ports:
//   CLK_125M, SYS_RST          clock, synchronous active-high reset
//   TRIG_TX_ICMP               parser trigger (rising edge is acted on)
//   ETH_ICMP_T*                capture stream from the parser (TLAST unused)
//   ETH_ICMP_TUSER             unfolded 16-bit-word sum of the echo body
//   PC_MAC, PC_IP              destination addresses
//   ICMP_TX_T*                 reply byte stream to the MAC arbiter
//   ICMP_TX_BUSY               high from trigger acceptance to last handshake
//   ICMP_TX_DROP               one-cycle pulse per discarded trigger/byte
//   ICMP_DBG_STATE             current FSM state, for observation
module tx_icmp_reply #(
  parameter logic [47:0] FPGA_MAC   = 48'h00D0_0800_0002,
  parameter logic [31:0] FPGA_IP    = 32'hC0A8_006E,
  parameter int          ECHO_BYTES = 36
) (
  input  logic        CLK_125M,
  input  logic        SYS_RST,
  input  logic        TRIG_TX_ICMP,
  input  logic        ETH_ICMP_TVALID,
  output logic        ETH_ICMP_TREADY,
  input  logic        ETH_ICMP_TLAST,
  input  logic [7:0]  ETH_ICMP_TDATA,
  input  logic [31:0] ETH_ICMP_TUSER,
  input  logic [47:0] PC_MAC,
  input  logic [31:0] PC_IP,
  output logic [7:0]  ICMP_TX_TDATA,
  output logic        ICMP_TX_TVALID,
  input  logic        ICMP_TX_TREADY,
  output logic        ICMP_TX_TLAST,
  output logic        ICMP_TX_BUSY,
  output logic        ICMP_TX_DROP,
  output logic [1:0]  ICMP_DBG_STATE
);

  localparam int          CAP_LEN   = 3 + ECHO_BYTES;
  localparam int          FRAME_LEN = 38 + ECHO_BYTES;
  localparam int          CNT_W     = $clog2(CAP_LEN + 1);
  localparam int          IDX_W     = $clog2(CAP_LEN);
  localparam int          K_W       = $clog2(FRAME_LEN);
  localparam logic [15:0] IP_LEN    = 16'(20 + 4 + ECHO_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC1 = 2'd1,
    S_CALC2 = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [K_W-1:0]     k_q;
  logic               trig_prev_q;
  logic               drop_q;
  logic [31:0]        tuser_q;
  logic [47:0]        mac_q;
  logic [31:0]        ip_q;
  logic [31:0]        ip_sum_q, icmp_sum_q;
  logic [15:0]        ip_cs_q, icmp_cs_q;
  logic [7:0]         cap_mem [0:CAP_LEN-1];

  logic               trig_edge, cap_fire, cap_store, cap_full, send_fire;
  logic               last_byte;
  logic [7:0]         tx_byte;
  logic [31:0]        k_i;
  logic [IDX_W-1:0]   body_idx;
  logic               unused_tlast;

  // Capture length is count based, so the parser's TLAST carries no information.
  assign unused_tlast = ETH_ICMP_TLAST;

  // Add upper and lower halves, then fold the carry back in once more.
  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [16:0] a, b;
    a = {1'b0, s[31:16]} + {1'b0, s[15:0]};
    b = {1'b0, a[15:0]} + {16'h0, a[16]};
    return b[15:0];
  endfunction

  assign trig_edge = TRIG_TX_ICMP && !trig_prev_q;
  assign cap_fire  = (state_q == S_IDLE) && ETH_ICMP_TVALID && !SYS_RST;
  assign cap_store = cap_fire && (cnt_q < CNT_W'(CAP_LEN));
  // A final byte arriving with the trigger edge counts toward a full capture.
  assign cap_full  = (cnt_q == CNT_W'(CAP_LEN)) ||
                     (cap_store && (cnt_q == CNT_W'(CAP_LEN - 1)));
  assign last_byte = (k_q == K_W'(FRAME_LEN - 1));
  assign send_fire = (state_q == S_SEND) && ICMP_TX_TREADY;

  assign ICMP_TX_DROP   = drop_q;
  assign ICMP_TX_TDATA  = tx_byte;
  assign ICMP_DBG_STATE = state_q;

  always_comb begin
    state_d         = state_q;
    ETH_ICMP_TREADY = 1'b0;
    ICMP_TX_TVALID  = 1'b0;
    ICMP_TX_TLAST   = 1'b0;
    ICMP_TX_BUSY    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ETH_ICMP_TREADY = !SYS_RST;
        if (trig_edge && cap_full) state_d = S_CALC1;
      end
      S_CALC1: begin
        ICMP_TX_BUSY = 1'b1;
        state_d      = S_CALC2;
      end
      S_CALC2: begin
        ICMP_TX_BUSY = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        ICMP_TX_BUSY   = 1'b1;
        ICMP_TX_TVALID = 1'b1;
        ICMP_TX_TLAST  = last_byte;
        if (send_fire && last_byte) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reply byte selected by frame index; zero outside SEND.
  always_comb begin
    tx_byte  = 8'h00;
    k_i      = 32'(k_q);
    body_idx = IDX_W'(k_q - K_W'(35));
    case (k_i)
      0:  tx_byte = mac_q[47:40];
      1:  tx_byte = mac_q[39:32];
      2:  tx_byte = mac_q[31:24];
      3:  tx_byte = mac_q[23:16];
      4:  tx_byte = mac_q[15:8];
      5:  tx_byte = mac_q[7:0];
      6:  tx_byte = FPGA_MAC[47:40];
      7:  tx_byte = FPGA_MAC[39:32];
      8:  tx_byte = FPGA_MAC[31:24];
      9:  tx_byte = FPGA_MAC[23:16];
      10: tx_byte = FPGA_MAC[15:8];
      11: tx_byte = FPGA_MAC[7:0];
      12: tx_byte = 8'h08;
      13: tx_byte = 8'h00;
      14: tx_byte = 8'h45;
      15: tx_byte = 8'h00;
      16: tx_byte = IP_LEN[15:8];
      17: tx_byte = IP_LEN[7:0];
      18: tx_byte = cap_mem[0];
      19: tx_byte = cap_mem[1];
      20: tx_byte = 8'h00;
      21: tx_byte = 8'h00;
      22: tx_byte = cap_mem[2];
      23: tx_byte = 8'h01;
      24: tx_byte = ip_cs_q[15:8];
      25: tx_byte = ip_cs_q[7:0];
      26: tx_byte = FPGA_IP[31:24];
      27: tx_byte = FPGA_IP[23:16];
      28: tx_byte = FPGA_IP[15:8];
      29: tx_byte = FPGA_IP[7:0];
      30: tx_byte = ip_q[31:24];
      31: tx_byte = ip_q[23:16];
      32: tx_byte = ip_q[15:8];
      33: tx_byte = ip_q[7:0];
      34: tx_byte = 8'h00;
      35: tx_byte = 8'h00;
      36: tx_byte = icmp_cs_q[15:8];
      37: tx_byte = icmp_cs_q[7:0];
      default: begin
        // Echo body starts at capture index 3, frame index 38.
        if (k_i >= 32'd38 && k_i < 32'(FRAME_LEN)) tx_byte = cap_mem[body_idx];
      end
    endcase
    if (state_q != S_SEND) tx_byte = 8'h00;
  end

  always_ff @(posedge CLK_125M) begin
    if (cap_store) cap_mem[IDX_W'(cnt_q)] <= ETH_ICMP_TDATA;
  end

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      trig_prev_q <= 1'b0;
      drop_q      <= 1'b0;
      tuser_q     <= '0;
      mac_q       <= '0;
      ip_q        <= '0;
      ip_sum_q    <= '0;
      icmp_sum_q  <= '0;
      ip_cs_q     <= '0;
      icmp_cs_q   <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= TRIG_TX_ICMP;
      drop_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          k_q <= '0;
          if (cap_store) cnt_q <= cnt_q + CNT_W'(1);
          if (trig_edge) begin
            tuser_q <= ETH_ICMP_TUSER;
            mac_q   <= PC_MAC;
            ip_q    <= PC_IP;
            if (!cap_full) begin
              drop_q <= 1'b1;
              cnt_q  <= '0;
            end
          end
        end
        S_CALC1: begin
          icmp_sum_q <= {16'h0, fold16(tuser_q)} + 32'h0000_0000;
          ip_sum_q   <= 32'h0000_4500 + {16'h0, IP_LEN}
                      + {16'h0, cap_mem[0], cap_mem[1]} + 32'h0000_0000
                      + {16'h0, cap_mem[2], 8'h01}
                      + {16'h0, FPGA_IP[31:16]} + {16'h0, FPGA_IP[15:0]}
                      + {16'h0, ip_q[31:16]} + {16'h0, ip_q[15:0]};
        end
        S_CALC2: begin
          ip_cs_q   <= ~fold16(ip_sum_q);
          icmp_cs_q <= ~fold16(icmp_sum_q);
          cnt_q     <= '0;
        end
        S_SEND: begin
          if (send_fire) k_q <= last_byte ? '0 : k_q + K_W'(1);
        end
        default: ;
      endcase
      // Anything arriving while a reply is in flight is thrown away.
      if (state_q != S_IDLE && (ETH_ICMP_TVALID || trig_edge)) drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_icmp_reply.sv
module tb_tx_icmp_reply;

  localparam int CAP  = 39;
  localparam int FLEN = 74;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        trig;
  logic        eth_tvalid, eth_tready, eth_tlast;
  logic [7:0]  eth_tdata;
  logic [31:0] eth_tuser;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tready, tx_tlast, tx_busy, tx_drop;
  logic [1:0]  dbg_state;

  always #4 clk = ~clk;

  tx_icmp_reply dut (
    .CLK_125M       (clk),
    .SYS_RST        (sys_rst),
    .TRIG_TX_ICMP   (trig),
    .ETH_ICMP_TVALID(eth_tvalid),
    .ETH_ICMP_TREADY(eth_tready),
    .ETH_ICMP_TLAST (eth_tlast),
    .ETH_ICMP_TDATA (eth_tdata),
    .ETH_ICMP_TUSER (eth_tuser),
    .PC_MAC         (pc_mac),
    .PC_IP          (pc_ip),
    .ICMP_TX_TDATA  (tx_tdata),
    .ICMP_TX_TVALID (tx_tvalid),
    .ICMP_TX_TREADY (tx_tready),
    .ICMP_TX_TLAST  (tx_tlast),
    .ICMP_TX_BUSY   (tx_busy),
    .ICMP_TX_DROP   (tx_drop),
    .ICMP_DBG_STATE (dbg_state)
  );

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] idf;
    logic [7:0]  ttl;
    logic [31:0] tuser;
    logic [7:0]  seed;
    bit          same_cycle;
    bit          bp;
    logic [15:0] ip_cs;
    logic [15:0] icmp_cs;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  cap_bytes [CAP];
  logic [7:0]  exp_frame [FLEN];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic build(input vec_t v);
    logic [47:0] fm;
    logic [31:0] fi;
    fm = 48'h00D0_0800_0002;
    fi = 32'hC0A8_006E;
    cap_bytes[0] = v.idf[15:8];
    cap_bytes[1] = v.idf[7:0];
    cap_bytes[2] = v.ttl;
    for (int i = 0; i < 36; i++) begin
      if (v.seed == 8'h00) cap_bytes[3+i] = (i == 1 || i == 3) ? 8'h01 : 8'h00;
      else cap_bytes[3+i] = v.seed + 8'(i * 3);
    end
    for (int i = 0; i < 6; i++) begin
      exp_frame[i]   = v.mac[47-8*i -: 8];
      exp_frame[6+i] = fm[47-8*i -: 8];
    end
    exp_frame[12] = 8'h08; exp_frame[13] = 8'h00;
    exp_frame[14] = 8'h45; exp_frame[15] = 8'h00;
    exp_frame[16] = 8'h00; exp_frame[17] = 8'h3C;
    exp_frame[18] = v.idf[15:8]; exp_frame[19] = v.idf[7:0];
    exp_frame[20] = 8'h00; exp_frame[21] = 8'h00;
    exp_frame[22] = v.ttl; exp_frame[23] = 8'h01;
    exp_frame[24] = v.ip_cs[15:8]; exp_frame[25] = v.ip_cs[7:0];
    for (int i = 0; i < 4; i++) begin
      exp_frame[26+i] = fi[31-8*i -: 8];
      exp_frame[30+i] = v.ip[31-8*i -: 8];
    end
    exp_frame[34] = 8'h00; exp_frame[35] = 8'h00;
    exp_frame[36] = v.icmp_cs[15:8]; exp_frame[37] = v.icmp_cs[7:0];
    for (int i = 0; i < 36; i++) exp_frame[38+i] = cap_bytes[3+i];
  endtask

  // Drives n capture bytes then a one-cycle trigger; returns 1 ns after the
  // edge that sampled the trigger.
  task automatic drive_capture(input int n, input bit trig_with_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      eth_tvalid = 1'b1;
      eth_tdata  = cap_bytes[i];
      if (i == n - 1 && trig_with_last) trig = 1'b1;
    end
    @(posedge clk); #1;
    eth_tvalid = 1'b0;
    if (!trig_with_last) begin
      trig = 1'b1;
      @(posedge clk); #1;
    end
    trig = 1'b0;
  endtask

  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, " busy t+1"}, tx_busy, 1'b1);
    chk({name, " tvalid t+1"}, tx_tvalid, 1'b0);
    @(negedge clk);
    chk({name, " tvalid t+2"}, tx_tvalid, 1'b0);
    @(negedge clk);
    chk({name, " tvalid t+3"}, tx_tvalid, 1'b1);
  endtask

  // Starts at a negedge with the frame's first byte on the bus.
  task automatic collect(input bit bp, input int stop_at, input string name);
    int         k = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;
    while (k < FLEN && k != stop_at && cyc < 2000) begin
      chk($sformatf("%s tvalid k%0d", name, k), tx_tvalid, 1'b1);
      if (stalled) begin
        chk($sformatf("%s stall data k%0d", name, k), tx_tdata, pd);
        chk($sformatf("%s stall last k%0d", name, k), tx_tlast, pl);
      end
      if (tx_tready) begin
        chk($sformatf("%s byte%0d", name, k), tx_tdata, exp_frame[k]);
        chk($sformatf("%s tlast%0d", name, k), tx_tlast, (k == FLEN - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = tx_tdata;
        pl = tx_tlast;
      end
      if (k < FLEN && k != stop_at) begin
        @(posedge clk); #1;
        tx_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    chk({name, " byte count"}, k, (stop_at >= 0) ? stop_at : FLEN);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    build(v);
    @(posedge clk); #1;
    eth_tuser = v.tuser;
    pc_mac    = v.mac;
    pc_ip     = v.ip;
    tx_tready = 1'b1;
    drive_capture(CAP, v.same_cycle);
    check_latency(name);
    collect(v.bp, -1, name);
    @(negedge clk);
    chk({name, " tvalid after"}, tx_tvalid, 1'b0);
    chk({name, " busy after"}, tx_busy, 1'b0);
    chk({name, " tready after"}, eth_tready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drops, rdy_hi, late_valid;

    vecs[0] = '{48'h0011_2233_4455, 32'hC0A8_0064, 16'h1234, 8'h80, 32'h0000_0002,
                8'h00, 1'b0, 1'b0, 16'hA66A, 16'hFFFD};
    vecs[1] = '{48'hA1B2_C3D4_E5F6, 32'hC0A8_0001, 16'h0000, 8'h40, 32'h0002_FFFF,
                8'h11, 1'b1, 1'b0, 16'hF901, 16'hFFFD};
    vecs[2] = '{48'hFFEE_DDCC_BBAA, 32'h0A00_0001, 16'hFFFF, 8'hFF, 32'h1234_5678,
                8'h5A, 1'b0, 1'b1, 16'hF0A9, 16'h9753};
    vecs[3] = '{48'h0011_2233_4455, 32'hC0A8_0064, 16'h1234, 8'h80, 32'h0000_0002,
                8'h00, 1'b0, 1'b1, 16'hA66A, 16'hFFFD};

    sys_rst    = 1'b1;
    trig       = 1'b0;
    eth_tvalid = 1'b0;
    eth_tlast  = 1'b0;
    eth_tdata  = 8'h00;
    eth_tuser  = 32'h0;
    pc_mac     = 48'h0;
    pc_ip      = 32'h0;
    tx_tready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tvalid", tx_tvalid, 1'b0);
    chk("rst tlast", tx_tlast, 1'b0);
    chk("rst tdata", tx_tdata, 8'h00);
    chk("rst busy", tx_busy, 1'b0);
    chk("rst drop", tx_drop, 1'b0);
    chk("rst tready", eth_tready, 1'b0);
    chk("rst state", dbg_state, 2'd0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("tready after rst", eth_tready, 1'b1);

    // Table of frames
    for (int v = 0; v < 4; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

    // Short capture: trigger rejected, then a normal reply
    build(vecs[0]);
    drive_capture(20, 1'b0);
    @(negedge clk);
    chk("short drop pulse", tx_drop, 1'b1);
    chk("short tvalid", tx_tvalid, 1'b0);
    chk("short busy", tx_busy, 1'b0);
    @(negedge clk);
    chk("short drop one cycle", tx_drop, 1'b0);
    late_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_tvalid) late_valid++;
    end
    chk("short no frame", late_valid, 0);
    run_frame(vecs[0], "after_short");

    // Busy collision: capture and trigger injected during SEND
    build(vecs[0]);
    @(posedge clk); #1;
    tx_tready = 1'b1;
    drive_capture(CAP, 1'b0);
    check_latency("coll");
    drops  = 0;
    rdy_hi = 0;
    fork
      collect(1'b0, -1, "coll");
      begin
        repeat (5) @(posedge clk);
        for (int i = 0; i < CAP; i++) begin
          #1;
          eth_tvalid = 1'b1;
          eth_tdata  = cap_bytes[i];
          @(posedge clk);
        end
        #1;
        eth_tvalid = 1'b0;
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
      end
      begin
        repeat (70) begin
          @(negedge clk);
          if (tx_drop) drops++;
          if (eth_tready) rdy_hi++;
        end
      end
    join
    chk("coll drop count", drops, 40);
    chk("coll tready low", rdy_hi, 0);
    late_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_tvalid) late_valid++;
    end
    chk("coll no second frame", late_valid, 0);
    run_frame(vecs[0], "after_coll");

    // Reset in the middle of a frame
    build(vecs[0]);
    @(posedge clk); #1;
    tx_tready = 1'b1;
    drive_capture(CAP, 1'b0);
    check_latency("rstmid");
    collect(1'b0, 40, "rstmid");
    @(posedge clk); #1;
    sys_rst   = 1'b1;
    tx_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid tvalid", tx_tvalid, 1'b0);
    chk("rstmid busy", tx_busy, 1'b0);
    chk("rstmid tlast", tx_tlast, 1'b0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    run_frame(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
